// File: rtl/page_data_scrambler_if.sv
// Page scrambler bus: page control, upstream beat channel and downstream beat channel.
// master = page buffer DMA / flash channel side, slave = scrambler.
interface page_data_scrambler_if #(
    parameter int unsigned LengthWidth = 16
);
    logic                   start;
    logic [7:0]             seed;
    logic [LengthWidth-1:0] length;
    logic                   bypass;
    logic [31:0]            in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;
    logic                   busy;
    logic                   done;

    modport master (
        output start, seed, length, bypass, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last, busy, done
    );

    modport slave (
        input  start, seed, length, bypass, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/page_data_scrambler.sv
// Streaming 32-bit page scrambler: 9-bit keystream expanded to four key bytes per beat,
// XORed onto page data behind a single output register stage.
module page_data_scrambler (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    page_data_scrambler_if.slave  bus_io
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned KS_W   = 9;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    function automatic logic [KS_W-1:0] ks_step(input logic [KS_W-1:0] s);
        return {s[7:0], s[0] ^ s[4] ^ s[5] ^ s[6] ^ s[8]};
    endfunction

    state_e              state_q, state_d;
    logic [KS_W-1:0]     ks_q, ks_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                bypass_q, bypass_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [KS_W-1:0]     ks1_c, ks2_c, ks3_c, ks4_c, seed_state_c;
    logic [DATA_W-1:0]   key_c;
    logic                in_ready_c, in_hs_c, out_hs_c, cnt_last_c;

    // Four keystream steps unrolled so a whole beat is keyed in one cycle
    assign ks1_c = ks_step(ks_q);
    assign ks2_c = ks_step(ks1_c);
    assign ks3_c = ks_step(ks2_c);
    assign ks4_c = ks_step(ks3_c);
    assign key_c = bypass_q ? '0 : {ks3_c[7:0], ks2_c[7:0], ks1_c[7:0], ks_q[7:0]};

    assign seed_state_c = {bus_io.seed,
                           bus_io.seed[0] ^ bus_io.seed[4] ^ bus_io.seed[5] ^ bus_io.seed[6]};

    assign in_ready_c = (state_q == RUN) && (!out_valid_q || bus_io.out_ready);
    assign in_hs_c    = bus_io.in_valid && in_ready_c;
    assign out_hs_c   = out_valid_q && bus_io.out_ready;
    assign cnt_last_c = (cnt_q == LEN_W'(1));

    always_comb begin
        state_d     = state_q;
        ks_d        = ks_q;
        cnt_d       = cnt_q;
        bypass_d    = bypass_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        if (out_hs_c) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (in_hs_c) begin
            out_data_d  = bus_io.in_data ^ key_c;
            out_valid_d = 1'b1;
            out_last_d  = cnt_last_c;
            cnt_d       = cnt_q - LEN_W'(1);
            if (!bypass_q) begin
                ks_d = ks4_c;
            end
        end

        unique case (state_q)
            IDLE: begin
                // A start coinciding with the done pulse still belongs to the finishing page
                if (bus_io.start && !done_q) begin
                    state_d  = RUN;
                    ks_d     = seed_state_c;
                    cnt_d    = bus_io.length;
                    bypass_d = bus_io.bypass;
                    busy_d   = 1'b1;
                end
            end
            RUN: begin
                if (in_hs_c && cnt_last_c) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_hs_c && out_last_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ks_q        <= '0;
            cnt_q       <= '0;
            bypass_q    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ks_q        <= ks_d;
            cnt_q       <= cnt_d;
            bypass_q    <= bypass_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus_io.in_ready  = in_ready_c;
    assign bus_io.out_data  = out_data_q;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.out_last  = out_last_q;
    assign bus_io.busy      = busy_q;
    assign bus_io.done      = done_q;
endmodule

// File: tb/tb_page_data_scrambler.sv
// Self-checking bench for page_data_scrambler: keystream model feeds a scoreboard that is
// drained by an output monitor on the falling clock edge.
module tb_page_data_scrambler;
    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    page_data_scrambler_if #(.LengthWidth(16)) bus ();

    page_data_scrambler dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    int   n_checks  = 0;
    int   n_errors  = 0;
    exp_t sb[$];
    bit   done_pend = 1'b0;
    int   done_cnt  = 0;
    int   rdy_mode  = 0;

    // Reference keystream model
    logic [8:0] m_s;
    int         m_cnt;
    bit         m_byp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] m_step(input logic [8:0] s);
        return {s[7:0], ^(s & 9'h171)};
    endfunction

    function automatic logic [31:0] m_key();
        logic [8:0]  t;
        logic [31:0] k;
        t = m_s;
        k = '0;
        if (m_byp) return k;
        for (int i = 0; i < 4; i++) begin
            k[8*i +: 8] = t[7:0];
            t = m_step(t);
        end
        return k;
    endfunction

    // Downstream ready pattern: 0 always ready, 1 repeating 1-0-0-1, 2 random
    initial begin
        bit [3:0] pat;
        int       cyc;
        pat = 4'b1001;
        cyc = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       bus.out_ready = pat[cyc % 4];
                2:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b1;
            endcase
            cyc++;
        end
    end

    // Output monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_pend = 1'b0;
            end else begin
                if (done_pend) begin
                    check("done_pulse", 32'(bus.done), 32'd1);
                    check("busy_fall", 32'(bus.busy), 32'd0);
                    done_pend = 1'b0;
                    done_cnt++;
                end else if (bus.done) begin
                    check("done_spurious", 32'(bus.done), 32'd0);
                end
                if (bus.out_valid) begin
                    if (sb.size() == 0) begin
                        check("sb_empty", 32'(sb.size()), 32'd1);
                    end else begin
                        e = sb[0];
                        check("out_data", bus.out_data, e.data);
                        check("out_last", 32'(bus.out_last), 32'(e.last));
                        if (bus.out_ready) begin
                            void'(sb.pop_front());
                            if (e.last) done_pend = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic start_page(input logic [7:0] seed, input logic [15:0] len, input bit byp);
        bus.start  = 1'b1;
        bus.seed   = seed;
        bus.length = len;
        bus.bypass = byp;
        m_s   = {seed, ^(seed & 8'h71)};
        m_cnt = (len == 16'd0) ? 65536 : int'(len);
        m_byp = byp;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("busy_rise", 32'(bus.busy), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] seed);
        bus.start = 1'b1;
        bus.seed  = seed;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input bit use_lit, input logic [31:0] lit);
        bit   hs;
        exp_t e;
        int   n;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = bus.in_ready;
            if (hs) begin
                e.data = use_lit ? lit : (d ^ m_key());
                e.last = (m_cnt == 1);
                sb.push_back(e);
                m_cnt--;
                if (!m_byp) for (int i = 0; i < 4; i++) m_s = m_step(m_s);
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) check("in_timeout", 32'(hs), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int c0;
        c0 = done_cnt;
        for (int i = 0; i < 400 && done_cnt == c0; i++) @(negedge clk);
        check("page_done", 32'(done_cnt > c0), 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  bus.out_data, 32'd0);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_last"},  32'(bus.out_last), 32'd0);
        check({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_busy"},  32'(bus.busy), 32'd0);
        check({tag, "_done"},  32'(bus.done), 32'd0);
    endtask

    task automatic mid_reset();
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        sb.delete();
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] d;
        bus.start    = 1'b0;
        bus.seed     = '0;
        bus.length   = '0;
        bus.bypass   = 1'b0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        m_s = '0; m_cnt = 0; m_byp = 1'b0;

        #12;
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Known-answer vectors, seed 0x01
        start_page(8'h01, 16'd2, 1'b0);
        send_beat(32'h0000_0000, 1'b1, 32'h1F0F0703);
        send_beat(32'h0000_0000, 1'b1, 32'hF2F97C3E);
        wait_done();

        start_page(8'h01, 16'd2, 1'b0);
        send_beat(32'hFFFF_FFFF, 1'b1, 32'hE0F0F8FC);
        send_beat(32'hFFFF_FFFF, 1'b1, 32'h0D0683C1);
        wait_done();

        start_page(8'h01, 16'd2, 1'b0);
        send_beat(32'hE0F0_F8FC, 1'b1, 32'hFFFFFFFF);
        send_beat(32'h0D06_83C1, 1'b1, 32'hFFFFFFFF);
        wait_done();

        // Bypass passes data untouched
        start_page(8'h5A, 16'd3, 1'b1);
        for (int i = 0; i < 3; i++) send_beat(32'h1234_5678, 1'b1, 32'h12345678);
        wait_done();

        // Backpressure 1-0-0-1
        rdy_mode = 1;
        start_page(8'h01, 16'd4, 1'b0);
        for (int i = 0; i < 4; i++) send_beat($urandom, 1'b0, '0);
        wait_done();
        rdy_mode = 0;

        // Start during RUN is ignored
        start_page(8'h01, 16'd4, 1'b0);
        send_beat(32'h0000_0000, 1'b1, 32'h1F0F0703);
        send_beat(32'h0000_0000, 1'b1, 32'hF2F97C3E);
        pulse_start(8'hFF);
        send_beat($urandom, 1'b0, '0);
        send_beat($urandom, 1'b0, '0);
        wait_done();

        // Seed 0x00 gives an identity scramble
        start_page(8'h00, 16'd2, 1'b0);
        for (int i = 0; i < 2; i++) begin
            d = $urandom;
            send_beat(d, 1'b1, d);
        end
        wait_done();

        // Single-beat page and random page under random backpressure
        start_page(8'hC3, 16'd1, 1'b0);
        send_beat($urandom, 1'b0, '0);
        wait_done();
        rdy_mode = 2;
        start_page(8'($urandom_range(1, 255)), 16'd6, 1'b0);
        for (int i = 0; i < 6; i++) send_beat($urandom, 1'b0, '0);
        wait_done();
        rdy_mode = 0;

        // Length 0 is a 65536-beat page: early beats must not be tagged last
        start_page(8'h37, 16'd0, 1'b0);
        for (int i = 0; i < 5; i++) send_beat($urandom, 1'b0, '0);
        mid_reset();

        // Reset mid-page, then the keystream restarts cleanly
        start_page(8'h01, 16'd8, 1'b0);
        send_beat($urandom, 1'b0, '0);
        send_beat($urandom, 1'b0, '0);
        mid_reset();
        start_page(8'h01, 16'd1, 1'b0);
        send_beat(32'h0000_0000, 1'b1, 32'h1F0F0703);
        wait_done();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
